// File: rtl/dmem_if.sv
// Bus between the ALU/register-file side and the data-memory stage.
// memByte exists only when DMEM_BYTE_ACCESS_EN is defined.
interface dmem_if #(
   parameter int N = 64
);
   logic [N-1:0] address;
   logic [N-1:0] writeData;
   logic         memRead;
   logic         memWrite;
   logic [N-1:0] readData;
   logic         stall;
   logic         fault;
`ifdef DMEM_BYTE_ACCESS_EN
   logic         memByte;

   modport master (
      output address, writeData, memRead, memWrite, memByte,
      input  readData, stall, fault
   );
   modport slave (
      input  address, writeData, memRead, memWrite, memByte,
      output readData, stall, fault
   );
`else
   modport master (
      output address, writeData, memRead, memWrite,
      input  readData, stall, fault
   );
   modport slave (
      input  address, writeData, memRead, memWrite,
      output readData, stall, fault
   );
`endif
endinterface

// File: rtl/dmem_stage.sv
// LEGv8 data-memory stage: serialized LDUR/STUR on an internal array with fixed wait states.
// Optional byte access (STURB/LDURB) enabled by defining DMEM_BYTE_ACCESS_EN.
module dmem_stage #(
   parameter int N           = 64,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
   localparam logic [N-1:0]  LIMIT    = N'(DEPTH * 8);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt, cnt_next;
   logic          fault_q, fault_next;
   logic          stall_c;
   logic          do_access;

   logic          req, byte_op, misaligned, out_of_range, illegal;

   logic [AW-1:0] idx_p0;
   logic [2:0]    lane_p0;
   logic [N-1:0]  data_p0;
   logic          wr_p0;
   logic          byte_p0;

   logic [AW-1:0] acc_idx;
   logic [2:0]    acc_lane;
   logic [N-1:0]  acc_data;
   logic          acc_wr;
   logic          acc_byte;

   logic [N-1:0]  mem [DEPTH];
   logic [N-1:0]  rdata;

`ifdef DMEM_BYTE_ACCESS_EN
   assign byte_op = bus.memByte;
`else
   assign byte_op = 1'b0;
`endif

   assign req          = bus.memRead | bus.memWrite;
   // Byte accesses may target any lane, so only doubleword accesses need alignment.
   assign misaligned   = ~byte_op & (bus.address[2:0] != 3'b000);
   assign out_of_range = (bus.address >= LIMIT);
   assign illegal      = (bus.memRead & bus.memWrite) | misaligned | out_of_range;

   // A zero-wait access happens straight from IDLE on live inputs; otherwise from latched ones.
   always_comb begin
      if (state == IDLE) begin
         acc_idx  = bus.address[AW+2:3];
         acc_lane = bus.address[2:0];
         acc_data = bus.writeData;
         acc_wr   = bus.memWrite;
         acc_byte = byte_op;
      end else begin
         acc_idx  = idx_p0;
         acc_lane = lane_p0;
         acc_data = data_p0;
         acc_wr   = wr_p0;
         acc_byte = byte_p0;
      end
   end

   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      fault_next = 1'b0;
      stall_c    = 1'b0;
      do_access  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               stall_c = 1'b1;
               if (illegal) begin
                  next_state = DONE;
                  fault_next = 1'b1;
               end else if (WAIT_CYCLES == 0) begin
                  next_state = DONE;
                  do_access  = 1'b1;
               end else begin
                  next_state = WAIT;
                  cnt_next   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (cnt == '0) begin
               next_state = DONE;
               do_access  = 1'b1;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         fault_q <= 1'b0;
      end else begin
         state   <= next_state;
         cnt     <= cnt_next;
         fault_q <= fault_next;
      end
   end

   // Request capture and array access
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (state == IDLE && req) begin
            idx_p0  <= bus.address[AW+2:3];
            lane_p0 <= bus.address[2:0];
            data_p0 <= bus.writeData;
            wr_p0   <= bus.memWrite;
            byte_p0 <= byte_op;
         end
         if (do_access) begin
            if (acc_wr) begin
               if (acc_byte) begin
                  mem[acc_idx][{acc_lane, 3'b000} +: 8] <= acc_data[7:0];
               end else begin
                  mem[acc_idx] <= acc_data;
               end
            end else if (acc_byte) begin
               rdata <= {{(N-8){1'b0}}, mem[acc_idx][{acc_lane, 3'b000} +: 8]};
            end else begin
               rdata <= mem[acc_idx];
            end
         end
      end
   end

   assign bus.readData = rdata;
   assign bus.stall    = stall_c;
   assign bus.fault    = fault_q;

endmodule

// File: tb/tb_dmem_stage.sv
// Directed scoreboard bench for dmem_stage (DEPTH=64, WAIT_CYCLES=2).
// Byte-access steps run only when DMEM_BYTE_ACCESS_EN is defined.
module tb_dmem_stage;
   localparam int WC = 2;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      logic [63:0] rd;
      logic        flt;
      int          stalls;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] mem_m [64];
   logic [63:0] last_rd;

   dmem_if #(.N(64)) bus ();

   dmem_stage #(.N(64), .DEPTH(64), .WAIT_CYCLES(WC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) mem_m[i] = '0;
      last_rd = '0;
   endtask

   // Drive one request at a negedge, hold it until the DONE cycle, then compare.
   task automatic access(input string tag, input logic rd, input logic wr, input logic bt,
                         input logic [63:0] a, input logic [63:0] d);
      exp_t e;
      int   stalls;
      bit   done;
      bit   ill;
      ill = (rd && wr) || (!bt && a[2:0] != 3'b000) || (a >= 64'd512);
      e.flt = ill;
      e.stalls = ill ? 1 : WC + 1;
      if (!ill) begin
         if (wr) begin
            if (bt) mem_m[a[8:3]][{a[2:0], 3'b000} +: 8] = d[7:0];
            else    mem_m[a[8:3]] = d;
         end else begin
            if (bt) last_rd = {56'd0, mem_m[a[8:3]][{a[2:0], 3'b000} +: 8]};
            else    last_rd = mem_m[a[8:3]];
         end
      end
      e.rd = last_rd;
      sb.push_back(e);

      bus.address   = a;
      bus.writeData = d;
      bus.memRead   = rd;
      bus.memWrite  = wr;
`ifdef DMEM_BYTE_ACCESS_EN
      bus.memByte   = bt;
`endif
      stalls = 0;
      done   = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (bus.stall) begin
            stalls++;
            @(negedge clk);
         end else begin
            done = 1;
         end
      end
      e = sb.pop_front();
      check({tag, "_stalls"}, 64'(stalls), 64'(e.stalls));
      check({tag, "_fault"}, {63'd0, bus.fault}, {63'd0, e.flt});
      check({tag, "_rdata"}, bus.readData, e.rd);
      bus.memRead  = 1'b0;
      bus.memWrite = 1'b0;
`ifdef DMEM_BYTE_ACCESS_EN
      bus.memByte  = 1'b0;
`endif
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.address   = '0;
      bus.writeData = '0;
      bus.memRead   = 1'b0;
      bus.memWrite  = 1'b0;
`ifdef DMEM_BYTE_ACCESS_EN
      bus.memByte   = 1'b0;
`endif
      model_clear();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_rdata", bus.readData, 64'd0);
      check("rst_stall", {63'd0, bus.stall}, 64'd0);
      check("rst_fault", {63'd0, bus.fault}, 64'd0);
      @(negedge clk);

      access("ld_0",       1, 0, 0, 64'h0,   64'h0);
      access("st_10",      0, 1, 0, 64'h10,  64'hDEADBEEF_CAFEF00D);
      access("ld_10",      1, 0, 0, 64'h10,  64'h0);
      access("ld_misal",   1, 0, 0, 64'h0C,  64'h0);
      access("ld_10_again",1, 0, 0, 64'h10,  64'h0);
      access("st_1f8",     0, 1, 0, 64'h1F8, 64'h0123_4567_89AB_CDEF);
      access("st_oor",     0, 1, 0, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF);
      access("rw_both",    1, 1, 0, 64'h1F8, 64'h5555_5555_5555_5555);
      access("ld_1f8",     1, 0, 0, 64'h1F8, 64'h0);

      // Abort a store while it is waiting
      bus.address   = 64'h20;
      bus.writeData = 64'h1234;
      bus.memWrite  = 1'b1;
      @(negedge clk);
      #1;
      check("mid_stall", {63'd0, bus.stall}, 64'd1);
      reset        = 1'b1;
      bus.memWrite = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_clear();
      check("abort_stall", {63'd0, bus.stall}, 64'd0);
      check("abort_fault", {63'd0, bus.fault}, 64'd0);
      check("abort_rdata", bus.readData, 64'd0);
      @(negedge clk);
      access("ld_20_after", 1, 0, 0, 64'h20, 64'h0);
      access("ld_10_after", 1, 0, 0, 64'h10, 64'h0);

`ifdef DMEM_BYTE_ACCESS_EN
      access("st_8",     0, 1, 0, 64'h8, 64'h11223344_55667788);
      access("stb_b",    0, 1, 1, 64'hB, 64'hAB);
      access("ld_8",     1, 0, 0, 64'h8, 64'h0);
      access("ldb_f",    1, 0, 1, 64'hF, 64'h0);
      access("stb_oor",  0, 1, 1, 64'h201, 64'hCC);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
